// File: rtl/mc_sequencer_if.sv
// Memory handshake between the multi-cycle control FSM and the shared instruction/data memory.
// The sequencer drives request/write/address-select and the memory answers with mem_ready.
interface mc_sequencer_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/mc_sequencer.sv
// Main control FSM for the multi-cycle MIPS datapath; memory states stretch on mem_ready.
// Optional macro MC_JUMP_EN enables the j instruction (opcode 000010); otherwise it halts as illegal.
module mc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  mc_sequencer_if.master   mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Raw (ungated) strobes; reset masks them at the port.
  logic req_raw, wr_raw, irw_raw, pcw_raw, br_raw, rw_raw;
  logic iord_raw;

  logic       funct_ok;
  logic [2:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default: begin
        funct_ok  = 1'b0;
        funct_alu = 3'b000;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_raw     = 1'b0;
    wr_raw      = 1'b0;
    irw_raw     = 1'b0;
    pcw_raw     = 1'b0;
    br_raw      = 1'b0;
    rw_raw      = 1'b0;
    iord_raw    = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_FETCH: begin
        req_raw     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        // IR and PC load only on the cycle the memory delivers the word.
        if (mem.mem_ready) begin
          irw_raw = 1'b1;
          pcw_raw = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_raw  = 1'b1;
        iord_raw = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rw_raw     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        req_raw  = 1'b1;
        wr_raw   = 1'b1;
        iord_raw = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_d     = funct_ok ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        rw_raw  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        br_raw      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw_raw  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pcw_raw = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
      end
`endif
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Retire: any entry into FETCH from another state completes an instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem.mem_req   = rst_n & req_raw;
  assign mem.mem_write = rst_n & wr_raw;
  assign mem.iord      = iord_raw;
  assign ir_write      = rst_n & irw_raw;
  assign pc_write      = rst_n & pcw_raw;
  assign branch        = rst_n & br_raw;
  assign reg_write     = rst_n & rw_raw;
  assign state_o       = state_q;
  assign instr_cnt     = cnt_q;

  a_write_needs_req: assert property (@(posedge clk) mem.mem_write |-> mem.mem_req);
  a_halt_quiet: assert property (@(posedge clk)
    halted |-> !(mem.mem_req || ir_write || pc_write || branch || reg_write));

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed vector bench for mc_sequencer (CNT_W=4 so the retire counter wraps quickly).
module tb_mc_sequencer;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [5:0]    opcode, funct;
  logic          ir_write, pc_write, branch, alu_src_a, reg_dst, mem_to_reg, reg_write, halted;
  logic [1:0]    pc_src, alu_src_b;
  logic [2:0]    alu_control;
  logic [3:0]    state_o;
  logic [CW-1:0] instr_cnt;

  mc_sequencer_if mif();

  mc_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .halted(halted), .state_o(state_o), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [21:0] act;
  logic [5:0]  strb;
  assign act  = {state_o, mif.mem_req, mif.mem_write, mif.iord, ir_write, pc_write, branch,
                 pc_src, alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, halted};
  assign strb = {mif.mem_req, mif.mem_write, ir_write, pc_write, branch, reg_write};

  function automatic logic [21:0] pk(input logic [3:0] st, input logic mq, mw, io, irw, pcw, br,
                                     input logic [1:0] ps, input logic asa, input logic [1:0] asb,
                                     input logic [2:0] alu, input logic rd, m2r, rw, h);
    return {st, mq, mw, io, irw, pcw, br, ps, asa, asb, alu, rd, m2r, rw, h};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]    opc;
    logic [5:0]    fn;
    logic          rdy;
    logic [21:0]   exp;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  logic [21:0] F_W, F_R, DEC, MADR, MRD, MWB, MWR, EX_ADD, EX_SUB, AWB, BR, AEX, AWB2, JMP, HLT;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, JOP = 6'b000010;

  // Drive one cycle's inputs at the falling edge, check 1ns later, move to next falling edge.
  task automatic cyc(input string nm, input logic [5:0] opc, input logic [5:0] fn, input logic rdy,
                     input logic [21:0] exp, input logic [CW-1:0] cnt);
    opcode = opc;
    funct  = fn;
    mif.mem_ready = rdy;
    #1;
    chk({nm, "_out"}, 32'(act), 32'(exp));
    chk({nm, "_cnt"}, 32'(instr_cnt), 32'(cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    F_W    = pk(4'd0, 1,0,0,0,0,0, 2'b00, 0, 2'b01, 3'b010, 0,0,0,0);
    F_R    = pk(4'd0, 1,0,0,1,1,0, 2'b00, 0, 2'b01, 3'b010, 0,0,0,0);
    DEC    = pk(4'd1, 0,0,0,0,0,0, 2'b00, 0, 2'b11, 3'b010, 0,0,0,0);
    MADR   = pk(4'd2, 0,0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 0,0,0,0);
    MRD    = pk(4'd3, 1,0,1,0,0,0, 2'b00, 0, 2'b00, 3'b000, 0,0,0,0);
    MWB    = pk(4'd4, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 0,1,1,0);
    MWR    = pk(4'd5, 1,1,1,0,0,0, 2'b00, 0, 2'b00, 3'b000, 0,0,0,0);
    EX_ADD = pk(4'd6, 0,0,0,0,0,0, 2'b00, 1, 2'b00, 3'b010, 0,0,0,0);
    EX_SUB = pk(4'd6, 0,0,0,0,0,0, 2'b00, 1, 2'b00, 3'b110, 0,0,0,0);
    AWB    = pk(4'd7, 0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 1,0,1,0);
    BR     = pk(4'd8, 0,0,0,0,0,1, 2'b01, 1, 2'b00, 3'b110, 0,0,0,0);
    AEX    = pk(4'd9, 0,0,0,0,0,0, 2'b00, 1, 2'b10, 3'b010, 0,0,0,0);
    AWB2   = pk(4'd10,0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 0,0,1,0);
    JMP    = pk(4'd11,0,0,0,0,1,0, 2'b10, 0, 2'b00, 3'b000, 0,0,0,0);
    HLT    = pk(4'd15,0,0,0,0,0,0, 2'b00, 0, 2'b00, 3'b000, 0,0,0,1);

    // add, sub (zero wait), lw (2 fetch waits + 3 read waits), sw (1 write wait), beq, addi
    tbl.push_back('{RT, 6'b100000, 1'b1, F_R, 4'd0});
    tbl.push_back('{RT, 6'b100000, 1'b1, DEC, 4'd0});
    tbl.push_back('{RT, 6'b100000, 1'b1, EX_ADD, 4'd0});
    tbl.push_back('{RT, 6'b100000, 1'b1, AWB, 4'd0});
    tbl.push_back('{RT, 6'b100010, 1'b1, F_R, 4'd1});
    tbl.push_back('{RT, 6'b100010, 1'b1, DEC, 4'd1});
    tbl.push_back('{RT, 6'b100010, 1'b1, EX_SUB, 4'd1});
    tbl.push_back('{RT, 6'b100010, 1'b1, AWB, 4'd1});
    tbl.push_back('{LW, 6'd0, 1'b0, F_W, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b0, F_W, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b1, F_R, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b1, DEC, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b1, MADR, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b0, MRD, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b0, MRD, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b0, MRD, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b1, MRD, 4'd2});
    tbl.push_back('{LW, 6'd0, 1'b1, MWB, 4'd2});
    tbl.push_back('{SW, 6'd0, 1'b1, F_R, 4'd3});
    tbl.push_back('{SW, 6'd0, 1'b1, DEC, 4'd3});
    tbl.push_back('{SW, 6'd0, 1'b1, MADR, 4'd3});
    tbl.push_back('{SW, 6'd0, 1'b0, MWR, 4'd3});
    tbl.push_back('{SW, 6'd0, 1'b1, MWR, 4'd3});
    tbl.push_back('{BEQ, 6'd0, 1'b1, F_R, 4'd4});
    tbl.push_back('{BEQ, 6'd0, 1'b1, DEC, 4'd4});
    tbl.push_back('{BEQ, 6'd0, 1'b1, BR, 4'd4});
    tbl.push_back('{ADDI, 6'd0, 1'b1, F_R, 4'd5});
    tbl.push_back('{ADDI, 6'd0, 1'b1, DEC, 4'd5});
    tbl.push_back('{ADDI, 6'd0, 1'b1, AEX, 4'd5});
    tbl.push_back('{ADDI, 6'd0, 1'b1, AWB2, 4'd5});
    tbl.push_back('{ADDI, 6'd0, 1'b0, F_W, 4'd6});

    // Reset state, strobes masked even with mem_ready high
    rst_n = 1'b0; opcode = RT; funct = 6'd0; mif.mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_strb", 32'(strb), 32'd0);
    mif.mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_strb_rdy", 32'(strb), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) cyc($sformatf("tbl%0d", i), tbl[i].opc, tbl[i].fn, tbl[i].rdy, tbl[i].exp, tbl[i].cnt);

    // Reset in the middle of a lw read
    cyc("mr_f", LW, 6'd0, 1'b1, F_R, 4'd6);
    cyc("mr_d", LW, 6'd0, 1'b1, DEC, 4'd6);
    cyc("mr_a", LW, 6'd0, 1'b1, MADR, 4'd6);
    cyc("mr_r", LW, 6'd0, 1'b0, MRD, 4'd6);
    rst_n = 1'b0; #1;
    chk("mr_strb_low", 32'(strb), 32'd0);
    chk("mr_state_low", 32'(state_o), 32'd3);
    @(negedge clk); mif.mem_ready = 1'b1; #1;
    chk("mr_state_after", 32'(state_o), 32'd0);
    chk("mr_cnt_after", 32'(instr_cnt), 32'd0);
    chk("mr_strb_after", 32'(strb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("mr_post", ADDI, 6'd0, 1'b1, F_R, 4'd0);
    cyc("mr_post_d", ADDI, 6'd0, 1'b1, DEC, 4'd0);
    cyc("mr_post_x", ADDI, 6'd0, 1'b1, AEX, 4'd0);
    cyc("mr_post_w", ADDI, 6'd0, 1'b1, AWB2, 4'd0);

    // Illegal opcode after one retired instruction: HALT holds, count frozen at 1
    cyc("io_f", 6'b111111, 6'd0, 1'b1, F_R, 4'd1);
    cyc("io_d", 6'b111111, 6'd0, 1'b1, DEC, 4'd1);
    for (int k = 0; k < 20; k++) cyc("io_halt", 6'b111111, 6'd0, 1'b1, HLT, 4'd1);

    // R-type with unsupported funct halts from EXECUTE without writeback
    do_reset();
    cyc("if_f", RT, 6'b000001, 1'b1, F_R, 4'd0);
    cyc("if_d", RT, 6'b000001, 1'b1, DEC, 4'd0);
    #1;
    chk("if_ex_state", 32'(state_o), 32'd6);
    chk("if_ex_rw", 32'(reg_write), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 20; k++) cyc("if_halt", RT, 6'b000001, 1'b1, HLT, 4'd0);

    // 17 addi with a 4-bit counter: wraps through 0 back to 1
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc("wr_f", ADDI, 6'd0, 1'b1, F_R, CW'(k));
      cyc("wr_d", ADDI, 6'd0, 1'b1, DEC, CW'(k));
      cyc("wr_x", ADDI, 6'd0, 1'b1, AEX, CW'(k));
      cyc("wr_w", ADDI, 6'd0, 1'b1, AWB2, CW'(k));
    end
    #1;
    chk("wrap_cnt", 32'(instr_cnt), 32'd1);
    chk("wrap_state", 32'(state_o), 32'd0);
    @(negedge clk);

    // Jump opcode
    do_reset();
    cyc("j_f", JOP, 6'd0, 1'b1, F_R, 4'd0);
    cyc("j_d", JOP, 6'd0, 1'b1, DEC, 4'd0);
`ifdef MC_JUMP_EN
    cyc("j_jump", JOP, 6'd0, 1'b1, JMP, 4'd0);
    cyc("j_ret", JOP, 6'd0, 1'b1, F_R, 4'd1);
`else
    cyc("j_halt", JOP, 6'd0, 1'b1, HLT, 4'd0);
    cyc("j_halt2", JOP, 6'd0, 1'b1, HLT, 4'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Main control FSM for the multi-cycle MIPS datapath: PC/IR/A/B/ALUOut registers, one shared instruction/data memory, one ALU.
- Sequences the datapath per instruction (fetch, decode, execute, memory, writeback) from the IR opcode/funct fields.
- Stretches memory states with a ready handshake so wait-state memories can be used.
- Counts retired instructions and halts on an illegal instruction.

Parameters:
CNT_W, 16, width of retired-instruction counter instr_cnt

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
opcode  in  6  Instr[31:26] from IR
funct  in  6  Instr[5:0] from IR
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access in progress
mem_write  out  1  access is a write (MemWrite)
iord  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  IR load strobe
pc_write  out  1  unconditional PC load
branch  out  1  conditional PC load (datapath ANDs with Zero)
pc_src  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=Data
reg_write  out  1  register file write strobe
halted  out  1  FSM in HALT
state_o  out  4  current state encoding (debug)
instr_cnt  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset: while rst_n=0 at a clk edge, state<=FETCH, instr_cnt<=0. Outputs are Moore decode of state, except that all strobes (mem_req, mem_write, ir_write, pc_write, branch, reg_write) are forced 0 while rst_n=0. Reset overrides everything, including mid-instruction and HALT.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 15.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00. ir_write and pc_write assert only in the cycle where mem_ready=1. Stay while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP (macro only)
  - else -> HALT
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1 every cycle of the state. Hold until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - other funct -> HALT (no writeback)
  - else -> ALUWB
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- JUMP: pc_write=1, pc_src=10. Next FETCH.
- HALT: halted=1, all strobes 0. Exit only via reset.
- Latencies at zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
- instr_cnt: +1 on every transition into FETCH from a non-FETCH state (retire). Never increments entering HALT. Wraps 2^CNT_W-1 -> 0.
- opcode/funct are used combinationally; IR is stable from DECODE until the next FETCH completes.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: opcode 000010 -> JUMP state, pc_write=1, pc_src=10.
- Undefined: opcode 000010 is illegal -> HALT; pc_src[1] is constant 0; state 11 unreachable.

Test Plan:
- Reset mid-instruction: rst_n=0 during MEMRD -> next edge state_o=0, instr_cnt=0, all strobes 0 while low; first post-reset cycle is FETCH.
- R-type add (opcode 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; reg_write=1 only in state 7 with reg_dst=1; alu_control=010 in state 6; instr_cnt +1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMRD -> 10 cycles total; ir_write/pc_write single-cycle pulse on the ready cycle; mem_to_reg=1 and reg_write=1 in MEMWB.
- sw then beq -> sw: mem_write=1 throughout MEMWR, iord=1. beq: state 8, alu_control=110, branch=1, pc_src=01; 3 cycles total.
- Illegal opcode 111111, and R-type with funct 000001 -> halted=1, state_o=15, no reg_write, held for 20 cycles, instr_cnt unchanged.
- CNT_W=4, 17 addi instructions -> instr_cnt reads 1 after wrap. Opcode 000010 -> JUMP/pc_src=10 with MC_JUMP_EN, HALT without.
